seg_scan_ctrl: RTL

Parametrised, time-multiplexed seven-segment display controller. It generalises the fixed 3-to-8 active-low digit selector into a scanning engine with configurable digit count, scan rate and inter-digit blanking. It also provides hex-to-segment decoding, per-digit decimal points and frame-coherent data capture. It sits between the datapath's display register (PC, register value, cycle count) and the board's shared segment/anode pins.

---
 rtl/seg_scan_if.sv | 30 +++
 rtl/seg_scan_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/seg_scan_if.sv
// Display-side bundle for seg_scan_ctrl: the datapath supplies nibbles, dp and enable;
// the controller returns the shared active-low anode/segment drive and the frame strobe.
interface seg_scan_if #(
    parameter int unsigned DIGITS = 8
);
    logic                  enable;
    logic [4*DIGITS-1:0]   data;
    logic [DIGITS-1:0]     dp;
    logic [DIGITS-1:0]     sel;
    logic [7:0]            seg;
    logic                  frame;

    modport master (
        output enable,
        output data,
        output dp,
        input  sel,
        input  seg,
        input  frame
    );

    modport slave (
        input  enable,
        input  data,
        input  dp,
        output sel,
        output seg,
        output frame
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with per-slot blanking and frame-coherent snapshot.
// Optional leading-zero blanking is built when SEG_SCAN_LZB_EN is defined.
module seg_scan_ctrl #(
    parameter int unsigned DIGITS = 8,
    parameter int unsigned DIV    = 100000,
    parameter int unsigned BLANK  = 1
) (
    input  logic        clk,
    input  logic        rst,
    seg_scan_if.slave   bus
);
    localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W  = $clog2(DIGITS);
    localparam int unsigned DATA_W = 4 * DIGITS;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  snap_q, snap_d;
    logic [DIGITS-1:0]  snap_dp_q, snap_dp_d;
    logic [DIGITS-1:0]  sel_q, sel_d;
    logic [7:0]         seg_q, seg_d;

    logic               slot_end_c;
    logic               frame_end_c;
    logic               blank_c;
    logic [3:0]         nib_c;
    logic [6:0]         glyph_c;

    // Active-low glyphs, bit order g,f,e,d,c,b,a.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign slot_end_c  = (cnt_q == CNT_W'(DIV - 1));
    assign frame_end_c = slot_end_c && (idx_q == IDX_W'(DIGITS - 1));

    // Strobe marks the capture cycle itself; a reset in that cycle suppresses the capture.
    assign bus.frame = frame_end_c && !rst;

    generate
        if (BLANK == 0) begin : g_no_blank
            assign blank_c = 1'b0;
        end else begin : g_blank
            assign blank_c = (cnt_q < CNT_W'(BLANK));
        end
    endgenerate

    assign nib_c = snap_q[{idx_q, 2'b00} +: 4];

`ifdef SEG_SCAN_LZB_EN
    logic [DIGITS-1:0] lz_c;

    // lz_c[k] is set when every nibble from the top down to k is zero; digit 0 always shows.
    always_comb begin
        logic run;
        lz_c = '0;
        run  = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run     = run && (snap_q[4*k +: 4] == 4'h0);
            lz_c[k] = run;
        end
    end

    assign glyph_c = lz_c[idx_q] ? 7'h7F : hex7(nib_c);
`else
    assign glyph_c = hex7(nib_c);
`endif

    // Scan position and snapshot advance.
    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        snap_d    = snap_q;
        snap_dp_d = snap_dp_q;
        if (slot_end_c) begin
            cnt_d = '0;
            if (idx_q == IDX_W'(DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
        if (frame_end_c) begin
            snap_d    = bus.data;
            snap_dp_d = bus.dp;
        end
    end

    // Next pin drive; blank slots and disable both turn every digit off.
    always_comb begin
        sel_d = '1;
        seg_d = 8'hFF;
        if (bus.enable && !blank_c) begin
            sel_d = ~(DIGITS'(1) << idx_q);
            seg_d = {~snap_dp_q[idx_q], glyph_c};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            snap_q    <= '0;
            snap_dp_q <= '0;
            sel_q     <= '1;
            seg_q     <= 8'hFF;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            snap_dp_q <= snap_dp_d;
            sel_q     <= sel_d;
            seg_q     <= seg_d;
        end
    end

    assign bus.sel = sel_q;
    assign bus.seg = seg_q;

endmodule
